// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequencer and its register file.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_L_SHIFT = 3'd1;
  localparam logic [2:0] OP_R_SHIFT = 3'd2;
  localparam logic [2:0] OP_AND     = 3'd3;
  localparam logic [2:0] OP_OR      = 3'd4;
  localparam logic [2:0] OP_COMP    = 3'd5;

  localparam logic [2:0] SEL_IDLE = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  function automatic logic is_legal(input logic [2:0] op);
    case (op)
      OP_ADD, OP_L_SHIFT, OP_R_SHIFT, OP_AND, OP_OR, OP_COMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers: three combinational read ports, one clocked write port.
module regfile4x8
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  input  logic [1:0]        raddr_dbg,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_dbg
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs[raddr_a];
  assign rdata_b   = regs[raddr_b];
  assign rdata_dbg = regs[raddr_dbg];

endmodule

// File: rtl/alu_sequencer.sv
// Issues one instruction at a time to the ALU result mux and writes the
// selected result back after SETTLE cycles of execution.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE = 1
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [1:0]        rd,
  input  logic [1:0]        rs1,
  input  logic [1:0]        rs2,
  input  logic              imm_en,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              err,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [1:0]        rd_q;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              accept;
  logic              wr_en;

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign wr_en       = (state == EXEC) && (cnt == LAST);

  regfile4x8 u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (wr_en),
    .waddr     (rd_q),
    .wdata     (alu_result),
    .raddr_a   (rs1),
    .raddr_b   (rs2),
    .raddr_dbg (dbg_sel),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .rdata_dbg (dbg_data)
  );

  // err doubles as the pending-error flag: set on an illegal accept, shown in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_q    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      alu_sel <= SEL_IDLE;
      wb_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_legal(opcode)) begin
              op_a    <= rdata_a;
              op_b    <= imm_en ? imm : rdata_b;
              rd_q    <= rd;
              alu_sel <= opcode;
              cnt     <= '0;
              state   <= EXEC;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= WB;
            end
          end
        end
        EXEC: begin
          if (wr_en) begin
            wb_data <= alu_result;
            alu_sel <= SEL_IDLE;
            done    <= 1'b1;
            state   <= WB;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: one instance at SETTLE=1 with a sum-returning mux,
// one at SETTLE=3 with a bench-driven result, checked against a register model.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_valid, a_ready, a_imm_en, a_done, a_err;
  logic [2:0] a_opcode, a_sel;
  logic [1:0] a_rd, a_rs1, a_rs2, a_dbg_sel;
  logic [7:0] a_imm, a_op_a, a_op_b, a_result, a_wb, a_dbg;

  logic       b_rst_n, b_valid, b_ready, b_imm_en, b_done, b_err;
  logic [2:0] b_opcode, b_sel;
  logic [1:0] b_rd, b_rs1, b_rs2, b_dbg_sel;
  logic [7:0] b_imm, b_op_a, b_op_b, b_result, b_wb, b_dbg;

  assign a_result = a_op_a + a_op_b;

  alu_sequencer dut_a (
    .clk(clk), .rst_n(a_rst_n), .instr_valid(a_valid), .instr_ready(a_ready),
    .opcode(a_opcode), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .imm_en(a_imm_en),
    .imm(a_imm), .op_a(a_op_a), .op_b(a_op_b), .alu_sel(a_sel),
    .alu_result(a_result), .wb_data(a_wb), .done(a_done), .err(a_err),
    .dbg_sel(a_dbg_sel), .dbg_data(a_dbg)
  );

  alu_sequencer #(.SETTLE(3)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .instr_valid(b_valid), .instr_ready(b_ready),
    .opcode(b_opcode), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .imm_en(b_imm_en),
    .imm(b_imm), .op_a(b_op_a), .op_b(b_op_b), .alu_sel(b_sel),
    .alu_result(b_result), .wb_data(b_wb), .done(b_done), .err(b_err),
    .dbg_sel(b_dbg_sel), .dbg_data(b_dbg)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] ref_regs [4];
  logic [7:0] ref_wb, ref_opa, ref_opb;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                                input logic [1:0] s2, input logic ie, input logic [7:0] im);
    a_opcode = op;
    a_rd     = d;
    a_rs1    = s1;
    a_rs2    = s2;
    a_imm_en = ie;
    a_imm    = im;
    a_valid  = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      a_dbg_sel = 2'(i);
      #1;
      check_output($sformatf("%s_dbg%0d", tag, i), a_dbg, ref_regs[i]);
    end
  endtask

  // One full instruction on instance A (SETTLE=1), checked cycle by cycle.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic [1:0] d,
                           input logic [1:0] s1, input logic [1:0] s2, input logic ie,
                           input logic [7:0] im);
    bit legal;
    legal = (op <= 3'd5);
    check_output({tag, "_ready"}, 8'(a_ready), 8'd1);
    check_output({tag, "_sel_pre"}, 8'(a_sel), 8'd7);
    apply_stimulus(op, d, s1, s2, ie, im);
    tick();
    a_valid = 1'b0;
    if (legal) begin
      ref_opa = ref_regs[s1];
      ref_opb = ie ? im : ref_regs[s2];
      check_output({tag, "_sel_exec"}, 8'(a_sel), 8'(op));
      check_output({tag, "_done_exec"}, 8'(a_done), 8'd0);
      check_output({tag, "_op_a"}, a_op_a, ref_opa);
      check_output({tag, "_op_b"}, a_op_b, ref_opb);
      tick();
      ref_regs[d] = ref_opa + ref_opb;
      ref_wb      = ref_opa + ref_opb;
    end
    check_output({tag, "_done"}, 8'(a_done), 8'd1);
    check_output({tag, "_err"}, 8'(a_err), legal ? 8'd0 : 8'd1);
    check_output({tag, "_sel_wb"}, 8'(a_sel), 8'd7);
    check_output({tag, "_wb"}, a_wb, ref_wb);
    check_output({tag, "_hold_a"}, a_op_a, ref_opa);
    check_output({tag, "_hold_b"}, a_op_b, ref_opb);
    tick();
    check_output({tag, "_ready_post"}, 8'(a_ready), 8'd1);
    check_output({tag, "_done_post"}, 8'(a_done), 8'd0);
  endtask

  initial begin
    logic [7:0] res;
    a_rst_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_rd = '0; a_rs1 = '0; a_rs2 = '0;
    a_imm_en = 1'b0; a_imm = '0; a_dbg_sel = '0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_opcode = '0; b_rd = '0; b_rs1 = '0; b_rs2 = '0;
    b_imm_en = 1'b0; b_imm = '0; b_dbg_sel = '0; b_result = '0;
    for (int i = 0; i < 4; i++) ref_regs[i] = '0;
    ref_wb = '0; ref_opa = '0; ref_opb = '0;

    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    $display("[TB] reset state");
    check_output("rst_ready", 8'(a_ready), 8'd1);
    check_output("rst_sel", 8'(a_sel), 8'd7);
    check_output("rst_done", 8'(a_done), 8'd0);
    check_output("rst_err", 8'(a_err), 8'd0);
    check_output("rst_wb", a_wb, 8'h00);
    check_output("rst_op_a", a_op_a, 8'h00);
    check_output("rst_op_b", a_op_b, 8'h00);
    check_regs("rst");

    $display("[TB] directed ADD sequence");
    run_instr("add_imm", OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
    check_output("add_imm_const", a_wb, 8'h05);
    run_instr("add_reg", OP_ADD, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00);
    check_output("add_reg_const", a_wb, 8'h0A);
    check_regs("add");

    $display("[TB] illegal opcode");
    run_instr("illegal", 3'd6, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00);
    check_regs("illegal");

    $display("[TB] back-to-back OR");
    apply_stimulus(OP_OR, 2'd2, 2'd1, 2'd0, 1'b1, 8'h30);
    res = ref_regs[1] + 8'h30;
    tick();
    check_output("bb_sel0", 8'(a_sel), 8'd4);
    tick();
    check_output("bb_sel1", 8'(a_sel), 8'd7);
    check_output("bb_done1", 8'(a_done), 8'd1);
    ref_regs[2] = res;
    tick();
    check_output("bb_sel2", 8'(a_sel), 8'd7);
    check_output("bb_ready2", 8'(a_ready), 8'd1);
    tick();
    a_valid = 1'b0;
    check_output("bb_sel3", 8'(a_sel), 8'd4);
    check_output("bb_ready3", 8'(a_ready), 8'd0);
    check_output("bb_op_a3", a_op_a, ref_regs[1]);
    tick();
    check_output("bb_done4", 8'(a_done), 8'd1);
    check_output("bb_wb4", a_wb, res);
    ref_wb  = res;
    ref_opa = ref_regs[1];
    ref_opb = 8'h30;
    tick();
    check_output("bb_ready5", 8'(a_ready), 8'd1);
    check_regs("bb");

    $display("[TB] random instructions");
    for (int n = 0; n < 24; n++) begin
      run_instr($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)));
    end
    check_regs("rnd");

    $display("[TB] SETTLE=3 late result");
    b_result = 8'h11;
    b_opcode = OP_ADD; b_rd = 2'd0; b_rs1 = 2'd0; b_imm_en = 1'b1; b_imm = 8'h01;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check_output("s3_sel0", 8'(b_sel), 8'd0);
    check_output("s3_op_a", b_op_a, 8'h00);
    check_output("s3_op_b", b_op_b, 8'h01);
    tick();
    check_output("s3_sel1", 8'(b_sel), 8'd0);
    check_output("s3_done1", 8'(b_done), 8'd0);
    tick();
    b_result = 8'h22;
    check_output("s3_sel2", 8'(b_sel), 8'd0);
    check_output("s3_done2", 8'(b_done), 8'd0);
    tick();
    check_output("s3_done3", 8'(b_done), 8'd1);
    check_output("s3_err3", 8'(b_err), 8'd0);
    check_output("s3_wb3", b_wb, 8'h22);
    check_output("s3_sel3", 8'(b_sel), 8'd7);
    tick();
    check_output("s3_ready4", 8'(b_ready), 8'd1);
    b_dbg_sel = 2'd0;
    #1;
    check_output("s3_dbg0", b_dbg, 8'h22);

    $display("[TB] reset during EXEC");
    b_result = 8'h33;
    b_opcode = OP_ADD; b_rd = 2'd3; b_rs1 = 2'd0; b_imm_en = 1'b1; b_imm = 8'h11;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check_output("rx_sel_exec", 8'(b_sel), 8'd0);
    check_output("rx_ready_exec", 8'(b_ready), 8'd0);
    b_rst_n = 1'b0;
    #1;
    check_output("rx_ready_rst", 8'(b_ready), 8'd1);
    check_output("rx_sel_rst", 8'(b_sel), 8'd7);
    check_output("rx_wb_rst", b_wb, 8'h00);
    tick();
    tick();
    b_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output($sformatf("rx_done%0d", k), 8'(b_done), 8'd0);
    end
    check_output("rx_ready_post", 8'(b_ready), 8'd1);
    b_dbg_sel = 2'd3;
    #1;
    check_output("rx_dbg3", b_dbg, 8'h00);
    b_dbg_sel = 2'd0;
    #1;
    check_output("rx_dbg0", b_dbg, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
